// File: rtl/weight_az_multi.sv
// weight_az_multi: G.729 Weight_Az bandwidth expansion of LPC coefficients, single or dual gamma, over a scratch memory
module weight_az_multi #(
   parameter int M  = 10,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          dual,
   input  logic [AW-1:0] A,
   input  logic [AW-1:0] AP1,
   input  logic [AW-1:0] AP2,
   input  logic [AW-1:0] gamma1Addr,
   input  logic [AW-1:0] gamma2Addr,
   output logic [AW-1:0] readAddr,
   input  logic [31:0]   readIn,
   output logic [AW-1:0] writeAddr,
   output logic [31:0]   writeData,
   output logic          writeEn,
   output logic          busy,
   output logic          done
);
   typedef enum logic [3:0] {IDLE, RG1, LG1, RG2, LG2, RA, CALC, WR1, WR2, DONE} state_t;
   state_t state, nextState;
   logic [AW-1:0] aBase, ap1Base, ap2Base, g1Base, g2Base;
   logic          dualReg;
   logic [3:0]    idx;
   logic [15:0]   aVal, gamma1, gamma2, fac1, fac2, ap1Val, ap2Val;
   logic          last, weNext, busyNext, doneNext;
   logic          unusedHi;

   function automatic logic [31:0] lMult(input logic [15:0] x, input logic [15:0] y);
      logic signed [31:0] p;
      p = $signed(x) * $signed(y);
      return (x == 16'h8000 && y == 16'h8000) ? 32'h7FFF_FFFF : p <<< 1;
   endfunction

   function automatic logic [15:0] rnd(input logic [31:0] l);
      logic [31:0] s;
      s = l + 32'h0000_8000;
      return (!l[31] && s[31]) ? 16'h7FFF : s[31:16];
   endfunction

   assign unusedHi = ^readIn[31:16];
   assign last = idx == 4'(M);
   assign ap1Val = (idx == 4'd0) ? aVal : rnd(lMult(aVal, fac1));
   assign ap2Val = (idx == 4'd0) ? aVal : rnd(lMult(aVal, fac2));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   // next-state: gamma fetch phase, then RA/CALC/WR1[/WR2] per coefficient
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = start ? RG1 : IDLE;
         RG1:     nextState = LG1;
         LG1:     nextState = dualReg ? RG2 : RA;
         RG2:     nextState = LG2;
         LG2:     nextState = RA;
         RA:      nextState = CALC;
         CALC:    nextState = WR1;
         WR1:     nextState = dualReg ? WR2 : (last ? DONE : RA);
         WR2:     nextState = last ? DONE : RA;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // outputs: memory addresses/data decoded from state, strobes computed one state ahead
   always_comb begin
      readAddr  = (state == RG1) ? g1Base : (state == RG2) ? g2Base : aBase + AW'(idx);
      writeAddr = (state == WR2) ? ap2Base + AW'(idx) : ap1Base + AW'(idx);
      writeData = {16'h0000, (state == WR2) ? ap2Val : ap1Val};
      weNext    = nextState == WR1 || nextState == WR2;
      busyNext  = nextState != IDLE && nextState != DONE;
      doneNext  = nextState == DONE;
   end

   // strobes are registered so writeEn/busy/done come straight from flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         writeEn <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         writeEn <= weNext;
         busy    <= busyNext;
         done    <= doneNext;
      end
   end

   // datapath: latch bases on start, load gammas and a[i], advance fac after each written term
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aBase   <= '0;
         ap1Base <= '0;
         ap2Base <= '0;
         g1Base  <= '0;
         g2Base  <= '0;
         dualReg <= 1'b0;
         idx     <= '0;
         aVal    <= '0;
         gamma1  <= '0;
         gamma2  <= '0;
         fac1    <= '0;
         fac2    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               aBase   <= A;
               ap1Base <= AP1;
               ap2Base <= AP2;
               g1Base  <= gamma1Addr;
               g2Base  <= gamma2Addr;
               dualReg <= dual;
               idx     <= '0;
            end
            LG1: begin
               gamma1 <= readIn[15:0];
               fac1   <= readIn[15:0];
            end
            LG2: begin
               gamma2 <= readIn[15:0];
               fac2   <= readIn[15:0];
            end
            CALC: aVal <= readIn[15:0];
            WR1: begin
               if (idx != 4'd0) fac1 <= rnd(lMult(fac1, gamma1));
               if (!dualReg) idx <= idx + 4'd1;
            end
            WR2: begin
               if (idx != 4'd0) fac2 <= rnd(lMult(fac2, gamma2));
               idx <= idx + 4'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_weight_az_multi.sv
// tb_weight_az_multi: scoreboard bench for weight_az_multi with directed, hand-computed vectors
module tb_weight_az_multi;
   localparam int AW = 12;
   localparam logic [15:0] HALF [11] = '{16'd4096, 16'd2048, 16'd1024, 16'd512, 16'd256, 16'd128,
                                         16'd64, 16'd32, 16'd16, 16'd8, 16'd4};
   localparam logic [15:0] SAT_A [11] = '{16'd5, 16'h8000, 16'h4000, 16'h4000, 16'd0, 16'd0,
                                          16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
   localparam logic [15:0] SAT_AP [11] = '{16'd5, 16'h7FFF, 16'h4000, 16'hC001, 16'd0, 16'd0,
                                           16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          dual = 1'b0;
   logic [AW-1:0] A = '0, AP1 = '0, AP2 = '0, g1 = '0, g2 = '0;
   logic [AW-1:0] readAddr, writeAddr;
   logic [31:0]   readIn = '0;
   logic [31:0]   writeData;
   logic          writeEn, busy, done;
   logic [31:0]   mem [0:4095];
   logic [AW-1:0] qa [$];
   logic [31:0]   qd [$];
   logic [AW-1:0] ea;
   logic [31:0]   ed;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   weight_az_multi dut (
      .clk(clk), .reset(reset), .start(start), .dual(dual),
      .A(A), .AP1(AP1), .AP2(AP2), .gamma1Addr(g1), .gamma2Addr(g2),
      .readAddr(readAddr), .readIn(readIn), .writeAddr(writeAddr),
      .writeData(writeData), .writeEn(writeEn), .busy(busy), .done(done)
   );

   // scratch memory: one-cycle read latency, write on strobe
   always @(posedge clk) begin
      readIn <= mem[readAddr];
      if (writeEn) mem[writeAddr] <= writeData;
   end

   // monitor: every write strobe is matched against the next expected word
   always @(negedge clk) begin
      if (writeEn) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h", writeAddr, writeData);
         end else begin
            ea = qa.pop_front();
            ed = qd.pop_front();
            if (writeAddr !== ea || writeData !== ed) begin
               bad++;
               $display("FAIL write got addr=%h data=%h want addr=%h data=%h", writeAddr, writeData, ea, ed);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic pushW(input logic [AW-1:0] ad, input logic [15:0] v);
      qa.push_back(ad);
      qd.push_back({16'h0000, v});
   endtask

   task automatic loadHalf(input logic [AW-1:0] base);
      for (int i = 0; i < 11; i++) mem[base + AW'(i)] = 32'h0000_1000;
   endtask

   task automatic go(input logic d, input int lat, input int pokeAt);
      int n;
      n = 201;
      start = 1'b1;
      dual = d;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         start = (k == pokeAt);
         if (k == pokeAt) begin
            dual = ~d;
            A = A + 12'h040;
            AP1 = AP1 + 12'h040;
            AP2 = AP2 + 12'h040;
            g1 = 12'h302;
         end
         if (done) begin
            n = k;
            break;
         end
      end
      start = 1'b0;
      check("latency", n, lat);
      check("busy_at_done", {31'd0, busy}, 0);
      check("writes_left", qa.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h300] = 32'h0000_4000;
      mem[12'h301] = 32'h0000_7FFF;
      mem[12'h302] = 32'h0000_8000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_we", {31'd0, writeEn}, 0);
      check("rst_raddr", {20'd0, readAddr}, 0);
      check("rst_waddr", {20'd0, writeAddr}, 0);
      check("rst_wdata", writeData, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      // single pass, gamma 0.5, a[] = 4096
      A = 12'h100; AP1 = 12'h200; AP2 = 12'h280; g1 = 12'h300; g2 = 12'h301;
      loadHalf(12'h100);
      for (int i = 0; i < 11; i++) pushW(12'h200 + AW'(i), HALF[i]);
      go(1'b0, 35, 0);
      // start during DONE is ignored, start in the following IDLE cycle is taken
      start = 1'b1;
      dual = 1'b1;
      @(posedge clk);
      #1;
      check("start_in_done_ignored", {31'd0, busy}, 0);
      check("done_one_cycle", {31'd0, done}, 0);
      mem[12'h100] = 32'h0000_0064;
      mem[12'h101] = 32'hFFFF_8000;
      for (int i = 2; i < 11; i++) mem[12'h100 + AW'(i)] = '0;
      pushW(12'h200, 16'd100);
      pushW(12'h280, 16'd100);
      pushW(12'h201, 16'hC000);
      pushW(12'h281, 16'h8001);
      for (int i = 2; i < 11; i++) begin
         pushW(12'h200 + AW'(i), 16'd0);
         pushW(12'h280 + AW'(i), 16'd0);
      end
      go(1'b1, 48, 0);
      @(posedge clk);
      #1;
      // saturation: gamma = a[1] = -1.0
      g1 = 12'h302;
      for (int i = 0; i < 11; i++) begin
         mem[12'h100 + AW'(i)] = {16'h0000, SAT_A[i]};
         pushW(12'h200 + AW'(i), SAT_AP[i]);
      end
      go(1'b0, 35, 0);
      @(posedge clk);
      #1;
      // address wrap at the top of the scratch memory
      A = 12'hFFC; AP1 = 12'hFFA; g1 = 12'h300;
      loadHalf(12'hFFC);
      for (int i = 0; i < 11; i++) pushW(12'hFFA + AW'(i), HALF[i]);
      go(1'b0, 35, 0);
      @(posedge clk);
      #1;
      // start pulse mid-pass with altered inputs must not disturb the pass
      A = 12'h100; AP1 = 12'h200; AP2 = 12'h280; g1 = 12'h300;
      loadHalf(12'h100);
      for (int i = 0; i < 11; i++) pushW(12'h200 + AW'(i), HALF[i]);
      go(1'b0, 35, 5);
      @(posedge clk);
      #1;
      check("single_done", {31'd0, done}, 0);
      check("idle_after_ignored", {31'd0, busy}, 0);
      // reset in the middle of the third write aborts the pass
      A = 12'h100; AP1 = 12'h600; g1 = 12'h300;
      for (int i = 0; i < 11; i++) mem[12'h600 + AW'(i)] = 32'h0000_DEAD;
      pushW(12'h600, HALF[0]);
      pushW(12'h601, HALF[1]);
      start = 1'b1;
      dual = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("we_before_abort", {31'd0, writeEn}, 1);
      #1 reset = 1'b0;
      #1;
      check("abort_we", {31'd0, writeEn}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_raddr", {20'd0, readAddr}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      check("abort_writes", qa.size(), 0);
      check("abort_kept0", mem[12'h600], 32'h0000_1000);
      check("abort_kept1", mem[12'h601], 32'h0000_0800);
      check("abort_untouched", mem[12'h602], 32'h0000_DEAD);
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) pushW(12'h600 + AW'(i), HALF[i]);
      go(1'b0, 35, 0);
      repeat (3) @(posedge clk);
      #1;
      check("final_queue", qa.size(), 0);
      check("final_ap1_10", mem[12'h60A], 32'h0000_0004);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
